// File: rtl/dff_serial_ctrl.sv
// Parallel-in/serial-out controller for a WIDTH-bit D-FF chain with busy/done handshake.
// Optional build macro PARITY_EN appends an even-parity bit after the data bits.
module dff_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             cp,
    input  logic             cr,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             msb_first,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Counter value at which the final SHIFT edge retires the transfer.
`ifdef PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dir, dir_n;
    logic             sout_n, busy_n, done_n;
`ifdef PARITY_EN
    logic             par, par_n;
`endif

    always_ff @(posedge cp) begin
        if (!cr) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
            sout  <= sout_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        dir_n   = dir;
        sout_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
`ifdef PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    q_n     = din;
                    dir_n   = msb_first;
                    sout_n  = msb_first ? din[WIDTH-1] : din[0];
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
`ifdef PARITY_EN
                    par_n   = ^din;
`endif
                end
            end
            SHIFT: begin
                // Chain zero-fills on every SHIFT edge, so it reads 0 once drained.
                q_n    = dir ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
                cnt_n  = cnt + CNT_W'(1);
                busy_n = 1'b1;
                if (cnt == CNT_W'(LAST)) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
`ifdef PARITY_EN
                end else if (cnt == CNT_W'(WIDTH - 1)) begin
                    sout_n = par;
`endif
                end else begin
                    sout_n = dir ? q[WIDTH-2] : q[1];
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dff_serial_ctrl.sv
// Randomized + directed bench for dff_serial_ctrl against a per-cycle expected-output queue model.
module tb_dff_serial_ctrl;

    localparam int WIDTH = 8;

    logic             cp = 1'b0;
    logic             cr = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             msb_first = 1'b0;
    logic             sout, busy, done;
    logic [WIDTH-1:0] q;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    dff_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .cp(cp), .cr(cr), .start(start), .din(din), .msb_first(msb_first),
        .sout(sout), .busy(busy), .done(done), .q(q)
    );

    always #10 cp = ~cp;

    typedef struct {
        logic             sout;
        logic             busy;
        logic             done;
        logic [WIDTH-1:0] q;
    } exp_t;

    // Front entry is the expected output for the current cycle; empty means idle.
    exp_t eq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    always @(posedge cp) begin
        if (!cr) begin
            eq.delete();
        end else if (eq.size() == 0) begin
            if (start) begin
                exp_t e;
                for (int i = 0; i < WIDTH; i++) begin
                    e.sout = msb_first ? din[WIDTH-1-i] : din[i];
                    e.busy = 1'b1;
                    e.done = 1'b0;
                    e.q    = msb_first ? (din << i) : (din >> i);
                    eq.push_back(e);
                end
`ifdef PARITY_EN
                e.sout = ^din;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.q    = '0;
                eq.push_back(e);
`endif
                e.sout = 1'b0;
                e.busy = 1'b0;
                e.done = 1'b1;
                e.q    = '0;
                eq.push_back(e);
            end
        end else begin
            void'(eq.pop_front());
        end
        armed <= 1'b1;
    end

    always @(negedge cp) begin
        if (armed) begin
            exp_t e;
            if (eq.size() == 0) begin
                e.sout = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.q = '0;
            end else begin
                e = eq[0];
            end
            chk("sout", 32'(sout), 32'(e.sout));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("q",    32'(q),    32'(e.q));
        end
    end

    task automatic step(input logic c, input logic s, input logic [WIDTH-1:0] d, input logic m);
        cr = c; start = s; din = d; msb_first = m;
        @(posedge cp);
        #1;
    endtask

    // Idle cycles with random din/msb_first to show they do not disturb a transfer.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, WIDTH'($urandom), 1'($urandom));
    endtask

    initial begin
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 8'hA5, 1'b1);  idle(11);
        step(1'b1, 1'b1, 8'h01, 1'b0);  idle(11);
        step(1'b1, 1'b1, 8'h3C, 1'b1);  idle(2);
        step(1'b1, 1'b1, 8'hC3, 1'b0);  idle(10);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 8'h3C, 1'b1);
        idle(12);
        step(1'b1, 1'b1, 8'hFF, 1'b1);  idle(4);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);  idle(11);
        step(1'b1, 1'b1, 8'h07, 1'b1);  idle(12);
        for (int i = 0; i < 2000; i++)
            step(1'(($urandom % 40) != 0), 1'(($urandom % 3) == 0),
                 WIDTH'($urandom), 1'($urandom));
        idle(12);
        @(negedge cp);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
